// File: rtl/ddr3_ref_clk_train_pkg.sv
// Shared types and constants for the DDR3 reference-clock training sequencer.
package ddr3_ref_clk_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_STEP,
        ST_DONE,
        ST_ERR
    } train_state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NO_EDGE = 2'b01;
    localparam logic [1:0] ERR_OOR     = 2'b10;

endpackage

// File: rtl/ddr3_ref_clk_sample_vote.sv
// Capture-and-vote unit: after a start pulse, takes NUM_SAMPLES consecutive
// samples of the phase-detector bit and reports the first value plus whether
// every capture agreed and no forced-unstable flag was seen.
module ddr3_ref_clk_sample_vote #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic sample_i,
    input  logic force_unstable_i,
    output logic done_o,
    output logic cur_o,
    output logic stable_o
);

    localparam int CNT_W = 5;

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             eq_q, eq_d;
    logic             flag_q, flag_d;

    assign done_o   = active_q && (cnt_q == CNT_W'(NUM_SAMPLES - 1));
    assign cur_o    = first_q;
    assign stable_o = eq_q && !flag_q;

    // Capture counter and running agreement of all samples against the first.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        eq_d     = eq_q;
        flag_d   = flag_q;
        if (start_i) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                first_d = sample_i;
                eq_d    = 1'b1;
                flag_d  = force_unstable_i;
            end else begin
                eq_d   = eq_q && (sample_i == first_q);
                flag_d = flag_q || force_unstable_i;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (done_o) begin
                active_d = 1'b0;
            end
        end
    end

    // Vote state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            eq_q     <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            eq_q     <= eq_d;
            flag_q   <= flag_d;
        end
    end

endmodule

// File: rtl/ddr3_ref_clk_train_ctrl.sv
// DDR3 reference-clock training sequencer: reloads the RX delay line, steps it
// tap by tap and reports the first tap where the sampled CK0 goes stable 0 ->
// stable 1. Optional eye-monitor support under macro REF_CLK_TRAIN_EYE_MON_EN.
module ddr3_ref_clk_train_ctrl
    import ddr3_ref_clk_train_pkg::*;
#(
    parameter int TAP_MAX       = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int NUM_SAMPLES   = 4
) (
    input  logic       FAB_CLK,
    input  logic       RESET,
    input  logic       TRAIN_START,
    output logic       TRAIN_BUSY,
    output logic       TRAIN_DONE,
    output logic       TRAIN_ERR,
    output logic [1:0] ERR_CODE,
    output logic [7:0] EDGE_TAP,
    input  logic [7:0] RX_DATA,
    input  logic       DELAY_LINE_OUT_OF_RANGE,
`ifdef REF_CLK_TRAIN_EYE_MON_EN
    input  logic       EYE_MONITOR_EARLY,
    input  logic       EYE_MONITOR_LATE,
`endif
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       EYE_MONITOR_CLEAR_FLAGS
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    train_state_e     state_q, state_d;
    logic [7:0]       tap_q, tap_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic             oor_q, oor_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [7:0]       edge_tap_q, edge_tap_d;

    logic load_c, move_c, settle_last, eye_flag;
    logic vote_done, vote_cur, vote_stable;
    logic unused_rx;

    assign unused_rx   = ^RX_DATA[7:1];
    assign settle_last = (state_q == ST_SETTLE) && (settle_q == '0);

`ifdef REF_CLK_TRAIN_EYE_MON_EN
    assign eye_flag                = EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
    assign EYE_MONITOR_CLEAR_FLAGS = settle_last;
`else
    assign eye_flag                = 1'b0;
    assign EYE_MONITOR_CLEAR_FLAGS = 1'b0;
`endif

    ddr3_ref_clk_sample_vote #(
        .NUM_SAMPLES(NUM_SAMPLES)
    ) u_vote (
        .clk_i           (FAB_CLK),
        .rst_i           (RESET),
        .start_i         (settle_last),
        .sample_i        (RX_DATA[0]),
        .force_unstable_i(eye_flag),
        .done_o          (vote_done),
        .cur_o           (vote_cur),
        .stable_o        (vote_stable)
    );

    assign TRAIN_BUSY           = (state_q != ST_IDLE);
    assign TRAIN_DONE           = done_q;
    assign TRAIN_ERR            = err_q;
    assign ERR_CODE             = err_code_q;
    assign EDGE_TAP             = edge_tap_q;
    assign DELAY_LINE_LOAD      = load_c;
    assign DELAY_LINE_MOVE      = move_c;
    assign DELAY_LINE_DIRECTION = move_c;

    // Next-state and pulse outputs of the training sequencer.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        settle_d     = settle_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        oor_d        = oor_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        edge_tap_d   = edge_tap_q;
        load_c       = 1'b0;
        move_c       = 1'b0;

        if (state_q != ST_IDLE && state_q != ST_LOAD) begin
            oor_d = oor_q | DELAY_LINE_OUT_OF_RANGE;
        end

        case (state_q)
            ST_IDLE: begin
                if (TRAIN_START) begin
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_c       = 1'b1;
                tap_d        = '0;
                prev_d       = 1'b0;
                prev_valid_d = 1'b0;
                oor_d        = 1'b0;
                settle_d     = SET_W'(SETTLE_CYCLES - 1);
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (vote_done) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (oor_q || DELAY_LINE_OUT_OF_RANGE) begin
                    err_code_d = ERR_OOR;
                    state_d    = ST_ERR;
                end else if (vote_stable && prev_valid_q && !prev_q && vote_cur) begin
                    state_d = ST_DONE;
                end else begin
                    if (vote_stable) begin
                        prev_d       = vote_cur;
                        prev_valid_d = 1'b1;
                    end
                    if (tap_q == 8'(TAP_MAX)) begin
                        err_code_d = ERR_NO_EDGE;
                        state_d    = ST_ERR;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                move_c   = 1'b1;
                tap_d    = tap_q + 8'd1;
                settle_d = SET_W'(SETTLE_CYCLES - 1);
                state_d  = ST_SETTLE;
            end
            ST_DONE: begin
                done_d     = 1'b1;
                edge_tap_d = tap_q;
                state_d    = ST_IDLE;
            end
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state registers; reset aborts any run in progress.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            settle_q     <= '0;
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            oor_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            edge_tap_q   <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            settle_q     <= settle_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            oor_q        <= oor_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            edge_tap_q   <= edge_tap_d;
        end
    end

endmodule

// File: tb/tb_ddr3_ref_clk_train_ctrl.sv
// Self-checking bench for ddr3_ref_clk_train_ctrl: an IOD model drives the
// phase-detector bit from a per-tap pattern, a reference model predicts each
// run's outcome into a scoreboard, and a monitor checks each completed run.
// Build with +define+REF_CLK_TRAIN_EYE_MON_EN to exercise the eye monitor.
module tb_ddr3_ref_clk_train_ctrl;

    localparam int TAP_MAX = 127;
    localparam int SETTLE  = 8;
    localparam int NS      = 4;

    logic       FAB_CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TRAIN_START = 1'b0;
    logic       TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
    logic [1:0] ERR_CODE;
    logic [7:0] EDGE_TAP;
    logic [7:0] RX_DATA = 8'h00;
    logic       OOR = 1'b0;
    logic       LOAD, MOVE, DIR, CLEAR;
`ifdef REF_CLK_TRAIN_EYE_MON_EN
    logic       EARLY = 1'b0;
    logic       LATE = 1'b0;
`endif

    always #5 FAB_CLK = ~FAB_CLK;

    ddr3_ref_clk_train_ctrl #(
        .TAP_MAX(TAP_MAX),
        .SETTLE_CYCLES(SETTLE),
        .NUM_SAMPLES(NS)
    ) dut (
        .FAB_CLK                (FAB_CLK),
        .RESET                  (RESET),
        .TRAIN_START            (TRAIN_START),
        .TRAIN_BUSY             (TRAIN_BUSY),
        .TRAIN_DONE             (TRAIN_DONE),
        .TRAIN_ERR              (TRAIN_ERR),
        .ERR_CODE               (ERR_CODE),
        .EDGE_TAP               (EDGE_TAP),
        .RX_DATA                (RX_DATA),
        .DELAY_LINE_OUT_OF_RANGE(OOR),
`ifdef REF_CLK_TRAIN_EYE_MON_EN
        .EYE_MONITOR_EARLY      (EARLY),
        .EYE_MONITOR_LATE       (LATE),
`endif
        .DELAY_LINE_LOAD        (LOAD),
        .DELAY_LINE_MOVE        (MOVE),
        .DELAY_LINE_DIRECTION   (DIR),
        .EYE_MONITOR_CLEAR_FLAGS(CLEAR)
    );

`ifdef REF_CLK_TRAIN_EYE_MON_EN
    localparam bit EYE_EN = 1'b1;
`else
    localparam bit EYE_EN = 1'b0;
`endif

    int    n_checks = 0;
    int    n_errors = 0;
    string cur_run = "reset";

    // Per-tap behaviour of the sampled clock: 0 stable low, 1 stable high, 2 toggling.
    int mode[0:TAP_MAX];
    int oor_tap = -1;
    int eye_tap = -1;

    typedef struct {
        bit is_done;
        int code;
        int tap;
        int moves;
        int clears;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %0d expected %0d", cur_run, name, act, exp);
        end
    endtask

    // Reference: walk the taps applying the training rules directly.
    function automatic exp_t model();
        exp_t e;
        bit   pv = 1'b0;
        int   prev = 0;
        e.is_done = 1'b0;
        e.code    = 0;
        e.tap     = 0;
        e.moves   = TAP_MAX;
        for (int t = 0; t <= TAP_MAX; t++) begin
            bit stable = (mode[t] != 2) && (t != eye_tap);
            int cur = (mode[t] == 1) ? 1 : 0;
            e.moves = t;
            if (t == oor_tap) begin
                e.code = 2;
                break;
            end
            if (stable && pv && prev == 0 && cur == 1) begin
                e.is_done = 1'b1;
                e.tap = t;
                break;
            end
            if (stable) begin
                prev = cur;
                pv = 1'b1;
            end
            if (t == TAP_MAX) e.code = 1;
        end
        e.clears = EYE_EN ? e.moves + 1 : 0;
        return e;
    endfunction

    // IOD model: tracks the delay-line tap from LOAD/MOVE and drives the samples.
    int         env_tap = 0;
    bit         tog = 1'b0;
    logic       rx0;
    always @(negedge FAB_CLK) begin
        if (LOAD) env_tap = 0;
        else if (MOVE) env_tap = env_tap + 1;
        tog = ~tog;
        if (env_tap > TAP_MAX) rx0 = 1'b0;
        else if (mode[env_tap] == 2) rx0 = tog;
        else rx0 = (mode[env_tap] == 1);
        RX_DATA = {7'($urandom_range(0, 127)), rx0};
        OOR = (env_tap == oor_tap);
`ifdef REF_CLK_TRAIN_EYE_MON_EN
        EARLY = (env_tap == eye_tap);
`endif
    end

    // Monitor: counts pulses and checks each completed run against the scoreboard.
    int moves_seen = 0, loads_seen = 0, clears_seen = 0, dir_bad = 0;
    bit busy_prev = 1'b0;
    always @(negedge FAB_CLK) begin
        exp_t e;
        if (RESET) begin
            moves_seen = 0; loads_seen = 0; clears_seen = 0; dir_bad = 0;
            busy_prev = 1'b0;
        end else begin
            if (MOVE) moves_seen++;
            if (LOAD) loads_seen++;
            if (CLEAR) clears_seen++;
            if (DIR != MOVE) dir_bad++;
            if (LOAD && MOVE) dir_bad++;
            if (busy_prev && !TRAIN_BUSY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_end", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("done", TRAIN_DONE, e.is_done);
                    chk("err", TRAIN_ERR, e.is_done ? 0 : 1);
                    chk("err_code", ERR_CODE, e.code);
                    if (e.is_done) chk("edge_tap", EDGE_TAP, e.tap);
                    chk("moves", moves_seen, e.moves);
                    chk("loads", loads_seen, 1);
                    chk("clears", clears_seen, e.clears);
                    chk("dir_pulse", dir_bad, 0);
                end
                moves_seen = 0; loads_seen = 0; clears_seen = 0; dir_bad = 0;
            end
            busy_prev = TRAIN_BUSY;
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, TRAIN_BUSY, 0);
        chk({tag, "_done"}, TRAIN_DONE, 0);
        chk({tag, "_err"}, TRAIN_ERR, 0);
        chk({tag, "_code"}, ERR_CODE, 0);
        chk({tag, "_edge"}, EDGE_TAP, 0);
        chk({tag, "_load"}, LOAD, 0);
        chk({tag, "_move"}, MOVE, 0);
        chk({tag, "_dir"}, DIR, 0);
        chk({tag, "_clear"}, CLEAR, 0);
    endtask

    task automatic do_reset();
        @(posedge FAB_CLK); #1 RESET = 1'b1; TRAIN_START = 1'b0;
        repeat (3) @(posedge FAB_CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic start_pulse();
        @(posedge FAB_CLK); #1 TRAIN_START = 1'b1;
        @(posedge FAB_CLK); #1 TRAIN_START = 1'b0;
        chk("start_busy", TRAIN_BUSY, 1);
        chk("start_done_clr", TRAIN_DONE, 0);
        chk("start_err_clr", TRAIN_ERR, 0);
        chk("start_code_clr", ERR_CODE, 0);
        chk("start_load", LOAD, 1);
    endtask

    task automatic run(input string name, input int mid_tap);
        int cyc = 0;
        bit pulsed = 1'b0;
        cur_run = name;
        sb.push_back(model());
        start_pulse();
        while (TRAIN_BUSY && cyc < 4000) begin
            @(posedge FAB_CLK); #1;
            TRAIN_START = 1'b0;
            if (!pulsed && mid_tap >= 0 && env_tap == mid_tap) begin
                TRAIN_START = 1'b1;
                pulsed = 1'b1;
            end
            cyc++;
        end
        TRAIN_START = 1'b0;
        if (TRAIN_BUSY) begin
            chk("run_timeout", TRAIN_BUSY, 0);
            sb.delete();
            do_reset();
        end
        repeat (3) @(posedge FAB_CLK);
    endtask

    task automatic fill_edge(input int edge_at);
        for (int t = 0; t <= TAP_MAX; t++) mode[t] = (t < edge_at) ? 0 : 1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        fill_edge(200);
        repeat (4) @(posedge FAB_CLK);
        #1 check_zero("reset");
        RESET = 1'b0;
        repeat (2) @(posedge FAB_CLK);

        // Edge at tap 10, with a START pulse mid-run that must be ignored.
        fill_edge(10);
        run("t1_edge10", 5);

        // Always high: no 0->1 edge, error after the last tap.
        fill_edge(0);
        run("t2_no_edge", -1);

        // Out of range at tap 5 takes precedence over a later edge.
        fill_edge(30); oor_tap = 5;
        run("t3_oor", -1);
        oor_tap = -1;

        // Jitter zone between stable 0 and stable 1 is skipped.
        fill_edge(7);
        for (int t = 4; t <= 6; t++) mode[t] = 2;
        run("t4_jitter", -1);

        // Reset in the middle of a run aborts it; a fresh start reloads.
        cur_run = "t5_abort";
        fill_edge(50);
        start_pulse();
        cyc = 0;
        while (env_tap != 20 && cyc < 2000) begin
            @(posedge FAB_CLK); #1;
            cyc++;
        end
        chk("reach_tap20", env_tap, 20);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge FAB_CLK); #1 check_zero("mid_reset");
        end
        RESET = 1'b0;
        @(posedge FAB_CLK); #1 chk("post_reset_busy", TRAIN_BUSY, 0);
        fill_edge(12);
        run("t5_restart", -1);

`ifdef REF_CLK_TRAIN_EYE_MON_EN
        // Eye-monitor flag during tap 8 moves the detected edge to tap 9.
        fill_edge(8); eye_tap = 8;
        run("t6_eye", -1);
        eye_tap = -1;
`endif

        // Randomised patterns.
        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0) begin
                int e = $urandom_range(1, 126);
                for (int t = 0; t <= TAP_MAX; t++) begin
                    if ($urandom_range(0, 9) == 0) mode[t] = 2;
                    else mode[t] = (t < e) ? 0 : 1;
                end
            end else begin
                for (int t = 0; t <= TAP_MAX; t++) begin
                    int w = $urandom_range(0, 9);
                    mode[t] = (w < 4) ? 0 : ((w < 8) ? 1 : 2);
                end
            end
            oor_tap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TAP_MAX)) : -1;
            eye_tap = (EYE_EN && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 40)) : -1;
            run($sformatf("rand%0d", r), -1);
        end
        oor_tap = -1;
        eye_tap = -1;

        cur_run = "end";
        repeat (5) @(posedge FAB_CLK);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
